// File: rtl/render_pkg.sv
// Shared constants and types for the scene renderer: sprite geometry, palette,
// bird ROM address layout, tilt encodings and the shadow-load FSM states.
package render_pkg;

    localparam int SPRITE_H      = 24;   // rows, along x
    localparam int SPRITE_W      = 34;   // columns, along y
    localparam int PIPE_W        = 52;
    localparam int PIPE_GAP      = 100;
    localparam int PIPE_EDGE     = 2;
    localparam int GROUND_X      = 104;
    localparam int STRIPE_PERIOD = 28;
    localparam int STRIPE_HALF   = 14;

    localparam logic [11:0] KEY_COLOR  = 12'hF0F;
    localparam logic [11:0] COL_BORDER = 12'h050;
    localparam logic [11:0] COL_BODY   = 12'h0C0;
    localparam logic [11:0] COL_GND_A  = 12'hDB5;
    localparam logic [11:0] COL_GND_B  = 12'hCA4;
    localparam logic [11:0] COL_SKY    = 12'h7CE;

    localparam int ROM_STATUS_W = 2;
    localparam int ROM_TILT_W   = 2;
    localparam int ROM_ROW_W    = 5;
    localparam int ROM_COL_W    = 6;
    localparam int ROM_ADDR_W   = ROM_STATUS_W + ROM_TILT_W + ROM_ROW_W + ROM_COL_W;

    typedef enum logic [1:0] {
        TILT_UP    = 2'd0,
        TILT_LEVEL = 2'd1,
        TILT_DOWN  = 2'd2
    } tilt_e;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_WAIT1 = 2'd1,
        LD_WAIT2 = 2'd2
    } load_state_e;

    typedef struct packed {
        logic signed [15:0] stage_shift;
        logic [1:0]         bird_status;
`ifdef RENDER_BIRD_TILT_EN
        logic signed [7:0]  bird_angle;
`endif
        logic signed [15:0] bird_pos_x;
        logic signed [15:0] bird_pos_y;
        logic signed [15:0] pipe1_pos_x;
        logic signed [15:0] pipe1_pos_y;
        logic signed [15:0] pipe2_pos_x;
        logic signed [15:0] pipe2_pos_y;
        logic signed [15:0] pipe3_pos_x;
        logic signed [15:0] pipe3_pos_y;
    } scene_t;

    typedef struct packed {
        logic valid;
        logic bird;
        logic border;
        logic body;
        logic ground;
        logic stripe_a;
    } pix_flags_t;

    // Signed modulo by STRIPE_PERIOD via a shifted compare-and-subtract ladder;
    // returns 1 when the folded position lies in the first half-period.
    function automatic logic stripe_is_a(input logic [16:0] v);
        logic [17:0] r;
        logic [17:0] step;
        r = v[16] ? (~{v[16], v} + 18'd1) : {1'b0, v};
        for (int k = 11; k >= 0; k--) begin
            step = 18'(STRIPE_PERIOD) << k;
            if (r >= step) r = r - step;
        end
        if (v[16] && (r != 18'd0)) r = 18'(STRIPE_PERIOD) - r;
        return r < 18'(STRIPE_HALF);
    endfunction

endpackage

// File: rtl/pipe_hit.sv
// Combinational hit test of one pixel against one pipe: body (anywhere in the
// pipe outside its gap) and border (edge band, a subset of body).
module pipe_hit
    import render_pkg::*;
(
    input  logic signed [15:0] pix_x_i,
    input  logic signed [15:0] pix_y_i,
    input  logic signed [15:0] pipe_x_i,
    input  logic signed [15:0] pipe_y_i,
    output logic               body_hit_o,
    output logic               border_hit_o
);

    localparam logic [16:0] PW17       = 17'(PIPE_W);
    localparam logic [16:0] HALF_GAP17 = 17'(PIPE_GAP / 2);
    localparam logic [16:0] EDGE17     = 17'(PIPE_EDGE);

    logic [16:0] dx;
    logic [16:0] dy;
    logic [16:0] adx;
    logic        in_y;
    logic        out_gap;

    // 17-bit differences keep far off-screen positions from wrapping.
    assign dx  = {pix_x_i[15], pix_x_i} - {pipe_x_i[15], pipe_x_i};
    assign dy  = {pix_y_i[15], pix_y_i} - {pipe_y_i[15], pipe_y_i};
    assign adx = dx[16] ? (~dx + 17'd1) : dx;

    assign in_y    = !dy[16] && (dy < PW17);
    assign out_gap = adx >= HALF_GAP17;

    assign body_hit_o   = in_y && out_gap;
    assign border_hit_o = body_hit_o &&
                          ((dy < EDGE17) || (dy >= PW17 - EDGE17) ||
                           (adx < HALF_GAP17 + EDGE17));

endmodule

// File: rtl/scene_renderer.sv
// Per-pixel compositor with frame-synchronous scene shadows and a 3-stage
// pipeline. Optional macro RENDER_BIRD_TILT_EN selects bird ROM banks by tilt.
module scene_renderer
    import render_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  new_frame,
    input  logic                  pix_valid,
    input  logic signed [15:0]    pix_x,
    input  logic signed [15:0]    pix_y,
    input  logic signed [15:0]    stage_shift,
    input  logic [1:0]            bird_status,
    input  logic signed [7:0]     bird_angle,
    input  logic signed [15:0]    bird_pos_x,
    input  logic signed [15:0]    bird_pos_y,
    input  logic signed [15:0]    pipe1_pos_x,
    input  logic signed [15:0]    pipe1_pos_y,
    input  logic signed [15:0]    pipe2_pos_x,
    input  logic signed [15:0]    pipe2_pos_y,
    input  logic signed [15:0]    pipe3_pos_x,
    input  logic signed [15:0]    pipe3_pos_y,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [11:0]           rom_data,
    output logic [11:0]           rgb,
    output logic                  rgb_valid,
    output logic [1:0]            dbg_load_state_o
);

    localparam logic [16:0] BIRD_H17 = 17'(SPRITE_H);
    localparam logic [16:0] BIRD_W17 = 17'(SPRITE_W);

    load_state_e             ld_state_q, ld_state_d;
    logic                    load_en;
    scene_t                  shadow_q, shadow_d, scene_in;
    tilt_e                   tilt;
    logic [16:0]             bird_dx, bird_dy;
    logic                    bird_hit;
    logic [2:0]              pipe_body, pipe_border;
    logic signed [15:0]      pipe_x [3];
    logic signed [15:0]      pipe_y [3];
    logic [16:0]             stripe_sum;
    pix_flags_t              s1_q, s1_d, s2_q;
    logic [ROM_ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [11:0]             rgb_q, rgb_d;
    logic                    rgb_valid_q;

    // Shadow load fires two clocks after new_frame; a repeat pulse restarts it.
    always_comb begin
        ld_state_d = ld_state_q;
        load_en    = 1'b0;
        case (ld_state_q)
            LD_IDLE:  if (new_frame) ld_state_d = LD_WAIT1;
            LD_WAIT1: ld_state_d = new_frame ? LD_WAIT1 : LD_WAIT2;
            LD_WAIT2: begin
                if (new_frame) begin
                    ld_state_d = LD_WAIT1;
                end else begin
                    load_en    = 1'b1;
                    ld_state_d = LD_IDLE;
                end
            end
            default:  ld_state_d = LD_IDLE;
        endcase
    end

    always_comb begin
        scene_in             = '0;
        scene_in.stage_shift = stage_shift;
        scene_in.bird_status = bird_status;
`ifdef RENDER_BIRD_TILT_EN
        scene_in.bird_angle  = bird_angle;
`endif
        scene_in.bird_pos_x  = bird_pos_x;
        scene_in.bird_pos_y  = bird_pos_y;
        scene_in.pipe1_pos_x = pipe1_pos_x;
        scene_in.pipe1_pos_y = pipe1_pos_y;
        scene_in.pipe2_pos_x = pipe2_pos_x;
        scene_in.pipe2_pos_y = pipe2_pos_y;
        scene_in.pipe3_pos_x = pipe3_pos_x;
        scene_in.pipe3_pos_y = pipe3_pos_y;
        shadow_d = load_en ? scene_in : shadow_q;
    end

`ifdef RENDER_BIRD_TILT_EN
    always_comb begin
        tilt = TILT_LEVEL;
        if ($signed(shadow_q.bird_angle) > 8'sd10)       tilt = TILT_UP;
        else if ($signed(shadow_q.bird_angle) < -8'sd30) tilt = TILT_DOWN;
    end
`else
    logic angle_unused;
    assign tilt         = TILT_LEVEL;
    assign angle_unused = ^bird_angle;
`endif

    // S1: hit tests against the shadowed scene.
    assign bird_dx  = {pix_x[15], pix_x} - {shadow_q.bird_pos_x[15], shadow_q.bird_pos_x};
    assign bird_dy  = {pix_y[15], pix_y} - {shadow_q.bird_pos_y[15], shadow_q.bird_pos_y};
    assign bird_hit = !bird_dx[16] && (bird_dx < BIRD_H17) &&
                      !bird_dy[16] && (bird_dy < BIRD_W17);

    assign pipe_x[0] = shadow_q.pipe1_pos_x;
    assign pipe_y[0] = shadow_q.pipe1_pos_y;
    assign pipe_x[1] = shadow_q.pipe2_pos_x;
    assign pipe_y[1] = shadow_q.pipe2_pos_y;
    assign pipe_x[2] = shadow_q.pipe3_pos_x;
    assign pipe_y[2] = shadow_q.pipe3_pos_y;

    for (genvar i = 0; i < 3; i++) begin : g_pipe
        pipe_hit u_pipe_hit (
            .pix_x_i      (pix_x),
            .pix_y_i      (pix_y),
            .pipe_x_i     (pipe_x[i]),
            .pipe_y_i     (pipe_y[i]),
            .body_hit_o   (pipe_body[i]),
            .border_hit_o (pipe_border[i])
        );
    end

    assign stripe_sum = {pix_y[15], pix_y} + {shadow_q.stage_shift[15], shadow_q.stage_shift};

    always_comb begin
        s1_d       = '0;
        rom_addr_d = rom_addr_q;
        if (pix_valid) begin
            s1_d.valid    = 1'b1;
            s1_d.bird     = bird_hit;
            s1_d.border   = |pipe_border;
            s1_d.body     = |pipe_body;
            s1_d.ground   = pix_x < 16'(GROUND_X);
            s1_d.stripe_a = stripe_is_a(stripe_sum);
            rom_addr_d    = {shadow_q.bird_status, tilt,
                             bird_dx[ROM_ROW_W-1:0], bird_dy[ROM_COL_W-1:0]};
        end
    end

    // S3: composite; rom_data belongs to the pixel now held in s2.
    always_comb begin
        rgb_d = '0;
        if (s2_q.valid) begin
            if (s2_q.bird && (rom_data != KEY_COLOR)) rgb_d = rom_data;
            else if (s2_q.border)                     rgb_d = COL_BORDER;
            else if (s2_q.body)                       rgb_d = COL_BODY;
            else if (s2_q.ground)                     rgb_d = s2_q.stripe_a ? COL_GND_A : COL_GND_B;
            else                                      rgb_d = COL_SKY;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ld_state_q  <= LD_IDLE;
            shadow_q    <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            rom_addr_q  <= '0;
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
        end else begin
            ld_state_q  <= ld_state_d;
            shadow_q    <= shadow_d;
            s1_q        <= s1_d;
            s2_q        <= s1_q;
            rom_addr_q  <= rom_addr_d;
            rgb_q       <= rgb_d;
            rgb_valid_q <= s2_q.valid;
        end
    end

    assign rom_addr         = rom_addr_q;
    assign rgb              = rgb_q;
    assign rgb_valid        = rgb_valid_q;
    assign dbg_load_state_o = ld_state_q;

endmodule

// File: tb/tb_scene_renderer.sv
// Directed bench for scene_renderer: stimulus pushes expected colours into a
// queue, an independent monitor pops and compares on every rgb_valid.
module tb_scene_renderer;

    localparam logic [11:0] SKY    = 12'h7CE;
    localparam logic [11:0] BODY   = 12'h0C0;
    localparam logic [11:0] BORDER = 12'h050;
    localparam logic [11:0] GND_A  = 12'hDB5;
    localparam logic [11:0] GND_B  = 12'hCA4;

    logic               clk = 1'b0;
    logic               rstn;
    logic               new_frame;
    logic               pix_valid;
    logic signed [15:0] pix_x, pix_y;
    logic signed [15:0] stage_shift;
    logic [1:0]         bird_status;
    logic signed [7:0]  bird_angle;
    logic signed [15:0] bird_pos_x, bird_pos_y;
    logic signed [15:0] pipe1_pos_x, pipe1_pos_y;
    logic signed [15:0] pipe2_pos_x, pipe2_pos_y;
    logic signed [15:0] pipe3_pos_x, pipe3_pos_y;
    logic [14:0]        rom_addr;
    logic [11:0]        rom_data;
    logic [11:0]        rom_val;
    logic [11:0]        rgb;
    logic               rgb_valid;
    logic [1:0]         dbg_load_state;

    logic [11:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    scene_renderer dut (
        .clk              (clk),
        .rstn             (rstn),
        .new_frame        (new_frame),
        .pix_valid        (pix_valid),
        .pix_x            (pix_x),
        .pix_y            (pix_y),
        .stage_shift      (stage_shift),
        .bird_status      (bird_status),
        .bird_angle       (bird_angle),
        .bird_pos_x       (bird_pos_x),
        .bird_pos_y       (bird_pos_y),
        .pipe1_pos_x      (pipe1_pos_x),
        .pipe1_pos_y      (pipe1_pos_y),
        .pipe2_pos_x      (pipe2_pos_x),
        .pipe2_pos_y      (pipe2_pos_y),
        .pipe3_pos_x      (pipe3_pos_x),
        .pipe3_pos_y      (pipe3_pos_y),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .rgb              (rgb),
        .rgb_valid        (rgb_valid),
        .dbg_load_state_o (dbg_load_state)
    );

    // clock / external ROM model (one-cycle read latency, bench-chosen word)
    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix(input logic signed [15:0] x, input logic signed [15:0] y,
                             input logic [11:0] e);
        pix_x     = x;
        pix_y     = y;
        pix_valid = 1'b1;
        exp_q.push_back(e);
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic commit_frame();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        repeat (3) tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin : monitor
        logic [11:0] e;
        if (rstn) begin
            if (rgb_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel actual=%0h required=none", rgb);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel_rgb", 32'(rgb), 32'(e));
                end
            end else begin
                check("idle_rgb_zero", 32'(rgb), 32'h0);
            end
        end
    end

    initial begin : stimulus
        int n;
        rstn        = 1'b0;
        new_frame   = 1'b0;
        pix_valid   = 1'b0;
        pix_x       = 16'sd200;
        pix_y       = 16'sd200;
        stage_shift = 16'sd0;
        bird_status = 2'd2;
        bird_angle  = 8'sd0;
        bird_pos_x  = -16'sd1000;
        bird_pos_y  = -16'sd1000;
        pipe1_pos_x = 16'sd680;
        pipe1_pos_y = 16'sd500;
        pipe2_pos_x = 16'sd600;
        pipe2_pos_y = -16'sd50;
        pipe3_pos_x = 16'sd0;
        pipe3_pos_y = -16'sd2000;
        rom_val     = 12'h000;

        // reset held with pix_valid toggling
        for (int i = 0; i < 8; i++) begin
            pix_valid = i[0];
            tick();
            check("reset_rgb", 32'(rgb), 32'h0);
            check("reset_rgb_valid", 32'(rgb_valid), 32'h0);
            check("reset_rom_addr", 32'(rom_addr), 32'h0);
        end
        pix_valid = 1'b0;
        rstn = 1'b1;
        tick();
        tick();
        check("reset_load_state", 32'(dbg_load_state), 32'h0);

        // first-pixel latency with all-zero shadows: (200,200) is sky
        drive_pix(16'sd200, 16'sd200, SKY);
        n = 1;
        while (!rgb_valid && n < 10) begin
            tick();
            n++;
        end
        check("first_latency", 32'(n), 32'd3);
        drain();

        // pipe scene
        commit_frame();
        check("idle_after_load", 32'(dbg_load_state), 32'h0);
        drive_pix(16'sd200, 16'sd520, BODY);
        drive_pix(16'sd200, 16'sd500, BORDER);
        drive_pix(16'sd680, 16'sd520, SKY);
        drive_pix(16'sd630, 16'sd520, BORDER);
        drive_pix(16'sd631, 16'sd520, SKY);
        drive_pix(16'sd628, 16'sd520, BODY);
        drive_pix(16'sd730, 16'sd520, BORDER);
        drive_pix(16'sd200, 16'sd549, BODY);
        drive_pix(16'sd200, 16'sd551, BORDER);
        drive_pix(16'sd200, 16'sd552, SKY);
        drive_pix(16'sd300, -16'sd20, BODY);
        drive_pix(16'sd300, -16'sd49, BORDER);
        drive_pix(16'sd300, -16'sd48, BODY);
        drive_pix(16'sd300, -16'sd51, SKY);
        drive_pix(16'sd50, 16'sd10, GND_A);
        drive_pix(16'sd50, 16'sd27, GND_B);
        drive_pix(16'sd50, 16'sd30, GND_A);
        drive_pix(16'sd103, 16'sd10, GND_A);
        drive_pix(16'sd104, 16'sd10, SKY);
        drain();

        // ground scroll
        stage_shift = 16'sd5;
        commit_frame();
        drive_pix(16'sd50, 16'sd10, GND_B);
        drive_pix(16'sd50, 16'sd8, GND_A);
        drive_pix(16'sd50, 16'sd23, GND_A);
        drain();

        // bird over pipe1
        bird_pos_x = 16'sd420;
        bird_pos_y = 16'sd500;
        commit_frame();
        rom_val = 12'h0F0;
        tick();
        drive_pix(16'sd421, 16'sd503, 12'h0F0);
        check("bird_rom_addr", 32'(rom_addr), 32'({2'd2, 2'd1, 5'd1, 6'd3}));
        drive_pix(16'sd444, 16'sd503, BODY);
        drive_pix(16'sd420, 16'sd533, 12'h0F0);
        drive_pix(16'sd420, 16'sd534, BODY);
        drive_pix(16'sd419, 16'sd503, BODY);
        drain();
        rom_val = 12'hF0F;
        tick();
        drive_pix(16'sd421, 16'sd503, BODY);
        drain();

        // shadow timing: input change alone has no effect until the load
        rom_val = 12'h123;
        bird_pos_y = 16'sd600;
        tick();
        drive_pix(16'sd421, 16'sd603, SKY);
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        check("load_pending_state", 32'(dbg_load_state), 32'h1);
        drive_pix(16'sd421, 16'sd603, SKY);
        tick();
        drive_pix(16'sd421, 16'sd603, 12'h123);
        drain();

        // repeated new_frame restarts the delay
        bird_pos_y = 16'sd500;
        new_frame = 1'b1;
        tick();
        tick();
        new_frame = 1'b0;
        tick();
        drive_pix(16'sd421, 16'sd603, 12'h123);
        drive_pix(16'sd421, 16'sd603, SKY);
        drain();

        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
